fifo_tx: RTL and testbench

Transmit-side byte buffer of the Zigbee baseband. The CPU writes PSDU bytes over APB into a 64-entry FIFO, then starts transmission. The block serializes each byte into two 4-bit O-QPSK symbols, low nibble first, one symbol every SYM_DIV clocks. The symbols feed the chip spreader/modulator. It is the transmit counterpart of the receive FIFO that collects CDR bits for APB readout.

---
 rtl/zigbee_tx_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 61 ++++++
 rtl/fifo_tx.sv | 191 +++++++++++++++++++
 tb/tb_fifo_tx.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/zigbee_tx_pkg.sv
// Shared constants and types for the Zigbee transmit byte buffer:
// APB register map, CTRL bit positions, FSM states and default symbol period.
package zigbee_tx_pkg;

  localparam logic [7:0] ADDR_DATA   = 8'h00;
  localparam logic [7:0] ADDR_CTRL   = 8'h04;
  localparam logic [7:0] ADDR_STATUS = 8'h08;

  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;

  // 50 MHz clock / 62.5 ksym/s O-QPSK symbol rate
  localparam int SYM_DIV_DEFAULT = 800;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND_LO,
    SEND_HI
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; head word is presented
// combinationally so a pop and its data land in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr_reg;
  logic [PTR_W:0]   rd_ptr_reg;
  logic             push_ok;
  logic             pop_ok;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]) &&
                 (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]);
  assign count = wr_ptr_reg - rd_ptr_reg;

  // full/empty come from the registered pointers, i.e. before this cycle's pop
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign rd_data = mem[rd_ptr_reg[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg[PTR_W-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (flush) begin
        rd_ptr_reg <= wr_ptr_reg;
      end else if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/fifo_tx.sv
// Zigbee transmit buffer: APB-loaded byte FIFO serialised into 4-bit O-QPSK
// symbols, low nibble first, one symbol every SYM_DIV clocks.
module fifo_tx
  import zigbee_tx_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 64,
  parameter int SYM_DIV = SYM_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [7:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic [3:0]  sym_out,
  output logic        sym_strobe,
  output logic        tx_busy,
  output logic        tx_done,
  output logic        fifo_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int NIB   = WIDTH / 2;
  localparam int CNT_W = (SYM_DIV > 1) ? $clog2(SYM_DIV) : 1;
  localparam logic [CNT_W-1:0] SYM_LAST = CNT_W'(SYM_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;

  tx_state_t        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [3:0]       sym_reg, sym_next;
  logic             strobe_reg, strobe_next;
  logic             done_reg, done_next;

  logic             access;
  logic             push;
  logic             pop;
  logic             flush;
  logic             start;
  logic             abort;
  logic             sym_term;
  logic [WIDTH-1:0] rd_data;
  logic             empty;
  logic             full;
  logic [PTR_W:0]   count;
  logic [31:0]      status;
  logic             unused_pwdata;

  assign unused_pwdata = ^pwdata[31:WIDTH];

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wr_data (pwdata[WIDTH-1:0]),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .count   (count)
  );

  assign access = psel && penable;
  assign push   = access && pwrite && (paddr == ADDR_DATA) && !full;
  assign start  = access && pwrite && (paddr == ADDR_CTRL) && pwdata[CTRL_START];
  assign abort  = access && pwrite && (paddr == ADDR_CTRL) && pwdata[CTRL_ABORT];

  always_comb begin
    status              = '0;
    status[0]           = empty;
    status[1]           = full;
    status[2]           = tx_busy;
    status[8+PTR_W:8]   = count;
  end

  assign pready = 1'b1;

  always_comb begin
    pslverr = 1'b0;
    prdata  = '0;
    if (access) begin
      case (paddr)
        ADDR_DATA:   pslverr = !pwrite || full;
        ADDR_CTRL:   pslverr = !pwrite;
        ADDR_STATUS: begin
          pslverr = pwrite;
          if (!pwrite) prdata = status;
        end
        default:     pslverr = 1'b1;
      endcase
    end
  end

  assign sym_term = (cnt_reg == SYM_LAST);

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    shift_next  = shift_reg;
    sym_next    = sym_reg;
    strobe_next = 1'b0;
    done_next   = 1'b0;
    pop         = 1'b0;
    flush       = 1'b0;
    if (abort) begin
      state_next = IDLE;
      flush      = 1'b1;
      sym_next   = '0;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          cnt_next = '0;
          if (start && !empty) state_next = LOAD;
        end
        LOAD: begin
          pop         = 1'b1;
          shift_next  = rd_data;
          sym_next    = rd_data[NIB-1:0];
          strobe_next = 1'b1;
          cnt_next    = '0;
          state_next  = SEND_LO;
        end
        SEND_LO: begin
          if (sym_term) begin
            sym_next    = shift_reg[WIDTH-1:NIB];
            strobe_next = 1'b1;
            cnt_next    = '0;
            state_next  = SEND_HI;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end
        SEND_HI: begin
          if (sym_term) begin
            cnt_next = '0;
            // chain straight into the next byte so the air interface sees no gap
            if (!empty) begin
              pop         = 1'b1;
              shift_next  = rd_data;
              sym_next    = rd_data[NIB-1:0];
              strobe_next = 1'b1;
              state_next  = SEND_LO;
            end else begin
              sym_next   = '0;
              done_next  = 1'b1;
              state_next = IDLE;
            end
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      shift_reg  <= '0;
      sym_reg    <= '0;
      strobe_reg <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      shift_reg  <= shift_next;
      sym_reg    <= sym_next;
      strobe_reg <= strobe_next;
      done_reg   <= done_next;
    end
  end

  assign sym_out    = sym_reg;
  assign sym_strobe = strobe_reg;
  assign tx_done    = done_reg;
  assign tx_busy    = (state_reg != IDLE);
  assign fifo_empty = empty;

endmodule

// File: tb/tb_fifo_tx.sv
// Scoreboard bench for fifo_tx: stimulus queues expected symbols and tx_done
// events, a negedge monitor pops and compares whenever the DUT strobes.
module tb_fifo_tx;

  localparam int SYM_DIV = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [7:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic [3:0]  sym_out;
  logic        sym_strobe;
  logic        tx_busy;
  logic        tx_done;
  logic        fifo_empty;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_done = 0;
  int strobe_cnt = 0;
  int cyc = 0;
  int last_cyc = 0;
  bit in_burst = 0;
  logic [3:0] last_sym = '0;
  logic [3:0] sym_q[$];

  fifo_tx #(.WIDTH(8), .DEPTH(64), .SYM_DIV(SYM_DIV)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr),
    .sym_out    (sym_out),
    .sym_strobe (sym_strobe),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .fifo_empty (fifo_empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // monitor: pops one expected symbol per strobe, checks spacing and tx_done
  always @(negedge clk) begin
    if (reset_n) begin
      cyc++;
      if (!tx_busy) in_burst = 0;
      if (sym_strobe) begin
        strobe_cnt++;
        n_checks++;
        if (sym_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_strobe: got sym 0x%0h, expected no symbol", sym_out);
        end else begin
          check("sym_out", 32'(sym_out), 32'(sym_q.pop_front()));
        end
        if (in_burst) check("sym_gap", 32'(cyc - last_cyc), 32'(SYM_DIV));
        in_burst = 1;
        last_cyc = cyc;
        last_sym = sym_out;
      end else if (in_burst) begin
        check("sym_hold", 32'(sym_out), 32'(last_sym));
      end
      if (tx_done) begin
        $display("tx_done seen at cycle %0d", cyc);
        check("done_busy", 32'(tx_busy), 32'd0);
        check("done_q_empty", 32'(sym_q.size()), 32'd0);
        n_checks++;
        if (exp_done == 0) begin
          n_fail++;
          $display("FAIL unexpected_tx_done: got pulse, expected none");
        end else begin
          exp_done--;
        end
      end
    end
  end

  task automatic apb_write(input logic [7:0] addr, input logic [31:0] data, output logic err);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
    @(negedge clk);
    penable = 1'b1;
    #1 err = pslverr;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    $display("APB write addr=0x%02h data=0x%08h pslverr=%0d", addr, data, err);
  endtask

  task automatic apb_read(input logic [7:0] addr, output logic [31:0] data, output logic err);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
    @(negedge clk);
    penable = 1'b1;
    #1 begin data = prdata; err = pslverr; end
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    $display("APB read  addr=0x%02h data=0x%08h pslverr=%0d", addr, data, err);
  endtask

  task automatic push_byte(input logic [7:0] b);
    logic e;
    apb_write(8'h00, {24'h0, b}, e);
    check("push_err", 32'(e), 32'd0);
  endtask

  task automatic expect_byte(input logic [7:0] b);
    sym_q.push_back(b[3:0]);
    sym_q.push_back(b[7:4]);
  endtask

  task automatic wait_strobes(input int n, input int budget);
    while (strobe_cnt < n && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    check("strobe_timeout", 32'(strobe_cnt >= n), 32'd1);
  endtask

  task automatic wait_done(input int budget);
    while (exp_done != 0 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    check("done_timeout", 32'(exp_done), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;

    repeat (3) @(negedge clk);
    check("rst_sym_out", 32'(sym_out), 32'd0);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_empty", 32'(fifo_empty), 32'd1);
    check("rst_prdata", prdata, 32'd0);
    reset_n = 1'b1;

    // reset state via STATUS
    apb_read(8'h08, rd, e);
    check("status_reset", rd, 32'h0000_0001);
    check("status_err", 32'(e), 32'd0);
    check("idle_sym", 32'(sym_out), 32'd0);

    // two bytes, start latency and symbol order
    push_byte(8'hA5);
    push_byte(8'h3C);
    expect_byte(8'hA5);
    expect_byte(8'h3C);
    exp_done = 1;
    apb_write(8'h04, 32'h1, e);
    check("start_err", 32'(e), 32'd0);
    check("load_busy", 32'(tx_busy), 32'd1);
    check("load_strobe", 32'(sym_strobe), 32'd0);
    @(negedge clk);
    check("first_strobe", 32'(sym_strobe), 32'd1);
    check("first_sym", 32'(sym_out), 32'h5);
    wait_done(100);
    check("burst1_empty", 32'(fifo_empty), 32'd1);

    // fill to full, reject overflow, send 128 symbols
    for (int i = 0; i < 64; i++) begin
      push_byte(8'(i * 7 + 3));
      expect_byte(8'(i * 7 + 3));
    end
    apb_write(8'h00, 32'hFF, e);
    check("overflow_err", 32'(e), 32'd1);
    apb_read(8'h08, rd, e);
    check("status_full", rd, 32'h0000_4002);
    strobe_cnt = 0;
    exp_done = 1;
    apb_write(8'h04, 32'h1, e);
    wait_done(64 * 2 * SYM_DIV + 50);
    check("full_sym_count", 32'(strobe_cnt), 32'd128);

    // start while empty, error accesses
    strobe_cnt = 0;
    apb_write(8'h04, 32'h1, e);
    check("start_empty_err", 32'(e), 32'd0);
    repeat (8) @(negedge clk);
    check("start_empty_busy", 32'(tx_busy), 32'd0);
    check("start_empty_strobes", 32'(strobe_cnt), 32'd0);
    apb_read(8'h00, rd, e);
    check("read_data_err", 32'(e), 32'd1);
    apb_read(8'h04, rd, e);
    check("read_ctrl_err", 32'(e), 32'd1);
    apb_write(8'h08, 32'h0, e);
    check("write_status_err", 32'(e), 32'd1);
    apb_write(8'h0C, 32'h55, e);
    check("unmapped_err", 32'(e), 32'd1);
    apb_read(8'h08, rd, e);
    check("status_after_err", rd, 32'h0000_0001);

    // abort during the second symbol
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    sym_q.push_back(4'h1);
    sym_q.push_back(4'h1);
    strobe_cnt = 0;
    apb_write(8'h04, 32'h1, e);
    wait_strobes(2, 40);
    apb_write(8'h04, 32'h2, e);
    check("abort_busy", 32'(tx_busy), 32'd0);
    check("abort_empty", 32'(fifo_empty), 32'd1);
    check("abort_sym", 32'(sym_out), 32'd0);
    repeat (12) @(negedge clk);
    check("abort_strobes", 32'(strobe_cnt), 32'd2);

    // append during SEND_HI of the last byte: no gap
    push_byte(8'h45);
    expect_byte(8'h45);
    expect_byte(8'h12);
    exp_done = 1;
    strobe_cnt = 0;
    apb_write(8'h04, 32'h1, e);
    wait_strobes(2, 40);
    push_byte(8'h12);
    wait_done(100);
    check("append_strobes", 32'(strobe_cnt), 32'd4);

    // asynchronous reset mid-symbol
    push_byte(8'h77);
    push_byte(8'h88);
    sym_q.push_back(4'h7);
    strobe_cnt = 0;
    apb_write(8'h04, 32'h1, e);
    wait_strobes(1, 40);
    #2 reset_n = 1'b0;
    #1;
    check("arst_sym", 32'(sym_out), 32'd0);
    check("arst_strobe", 32'(sym_strobe), 32'd0);
    check("arst_busy", 32'(tx_busy), 32'd0);
    check("arst_done", 32'(tx_done), 32'd0);
    check("arst_empty", 32'(fifo_empty), 32'd1);
    check("arst_pslverr", 32'(pslverr), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    check("arst_q", 32'(sym_q.size()), 32'd0);
    apb_read(8'h08, rd, e);
    check("status_post_arst", rd, 32'h0000_0001);
    repeat (4) @(negedge clk);
    check("final_pending_done", 32'(exp_done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
